// File: rtl/ks0108_pkg.sv
// KS0108 bus controller shared types.
// States, R/W pin levels and counter sizing.
package ks0108_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_SETUP,
    POLL_EHIGH,
    POLL_ELOW,
    SETUP,
    EHIGH,
    ELOW,
    DONE
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int phase_w(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ks0108_phase_timer.sv
// Loadable down-counter shared by all timed phases.
// Loads N-1 on phase entry; zero marks the phase's last cycle.
module ks0108_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load on phase entry, then count down and park at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ks0108_bus_controller.sv
// KS0108 LCD bus timing engine.
// One req/done transaction per access, optional busy polling.
module ks0108_bus_controller
  import ks0108_pkg::*;
#(
  parameter int CS_COUNT      = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 13,
  parameter int E_LOW_CYCLES  = 13,
  parameter int CS_ACTIVE_LOW = 1,
  parameter int AUTO_BUSY     = 1,
  parameter int POLL_LIMIT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic                  dc,
  input  logic [CS_COUNT-1:0]   cs_sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  ks_dc,
  output logic                  ks_rw,
  output logic                  ks_e,
  output logic [CS_COUNT-1:0]   ks_cs,
  output logic [DATA_WIDTH-1:0] ks_data_out,
  input  logic [DATA_WIDTH-1:0] ks_data_in,
  output logic                  ks_data_oe
);

  localparam int PW = phase_w(SETUP_CYCLES, E_HIGH_CYCLES,
                              E_LOW_CYCLES);
  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CS_COUNT-1:0] CS_OFF =
    (CS_ACTIVE_LOW != 0) ? '1 : '0;

  state_t state, state_d;

  logic                  wr_q, dc_q;
  logic [CS_COUNT-1:0]   cs_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [CW-1:0]         poll_cnt;
  logic                  stat_busy;
  logic                  poll_last;

  logic accept, cap_stat, cap_rd, poll_inc, set_to;
  logic tmr_ld, tmr_zero;
  logic [PW-1:0] tmr_lv;

  logic                  wr_n, dc_n;
  logic [CS_COUNT-1:0]   cs_n, cs_pin, cs_d;
  logic [DATA_WIDTH-1:0] wd_n, do_d;
  logic                  e_d, dc_d, rw_d, oe_d;

  assign poll_last = (poll_cnt == CW'(POLL_LIMIT - 1));

  ks0108_phase_timer #(.W(PW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_ld),
    .load_val (tmr_lv),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, datapath strobes and phase timer reload
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    cap_stat = 1'b0;
    cap_rd   = 1'b0;
    poll_inc = 1'b0;
    set_to   = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        accept  = 1'b1;
        state_d = (AUTO_BUSY != 0) ? POLL_SETUP : SETUP;
      end
      POLL_SETUP: if (tmr_zero) state_d = POLL_EHIGH;
      POLL_EHIGH: if (tmr_zero) begin
        cap_stat = 1'b1;
        state_d  = POLL_ELOW;
      end
      POLL_ELOW: if (tmr_zero) begin
        if (!stat_busy) begin
          state_d = SETUP;
        end else if (poll_last) begin
          set_to  = 1'b1;
          state_d = DONE;
        end else begin
          poll_inc = 1'b1;
          state_d  = POLL_SETUP;
        end
      end
      SETUP: if (tmr_zero) state_d = EHIGH;
      EHIGH: if (tmr_zero) begin
        cap_rd  = !wr_q;
        state_d = ELOW;
      end
      ELOW: if (tmr_zero) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tmr_ld = (state_d != state);
    tmr_lv = '0;
    unique case (1'b1)
      (state_d == POLL_SETUP) || (state_d == SETUP):
        tmr_lv = PW'(SETUP_CYCLES - 1);
      (state_d == POLL_EHIGH) || (state_d == EHIGH):
        tmr_lv = PW'(E_HIGH_CYCLES - 1);
      (state_d == POLL_ELOW) || (state_d == ELOW):
        tmr_lv = PW'(E_LOW_CYCLES - 1);
      default: tmr_lv = '0;
    endcase
  end

  // Pin values for the coming cycle; fresh request fields bypass the latch
  always_comb begin
    wr_n   = accept ? wr : wr_q;
    dc_n   = accept ? dc : dc_q;
    cs_n   = accept ? cs_sel : cs_q;
    wd_n   = accept ? wdata : wd_q;
    cs_pin = (CS_ACTIVE_LOW != 0) ? ~cs_n : cs_n;
    e_d    = 1'b0;
    cs_d   = CS_OFF;
    dc_d   = ks_dc;
    rw_d   = RW_READ;
    oe_d   = 1'b0;
    do_d   = ks_data_out;
    case (state_d)
      POLL_SETUP, POLL_EHIGH, POLL_ELOW: begin
        cs_d = cs_pin;
        dc_d = 1'b0;
        e_d  = (state_d == POLL_EHIGH);
      end
      SETUP, EHIGH, ELOW: begin
        cs_d = cs_pin;
        dc_d = dc_n;
        rw_d = wr_n ? RW_WRITE : RW_READ;
        oe_d = wr_n;
        do_d = wd_n;
        e_d  = (state_d == EHIGH);
      end
      default: ;
    endcase
  end

  // Request latch, poll bookkeeping and read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q      <= 1'b0;
      dc_q      <= 1'b0;
      cs_q      <= '0;
      wd_q      <= '0;
      poll_cnt  <= '0;
      stat_busy <= 1'b0;
      timeout   <= 1'b0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        wr_q <= wr;
        dc_q <= dc;
        cs_q <= cs_sel;
        wd_q <= wdata;
      end
      if (accept)        poll_cnt <= '0;
      else if (poll_inc) poll_cnt <= poll_cnt + 1'b1;
      if (cap_stat) stat_busy <= ks_data_in[DATA_WIDTH-1];
      if (cap_rd)   rdata <= ks_data_in;
      if (accept)      timeout <= 1'b0;
      else if (set_to) timeout <= 1'b1;
    end
  end

  // Registered pins and handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      ks_e        <= 1'b0;
      ks_cs       <= CS_OFF;
      ks_dc       <= 1'b0;
      ks_rw       <= RW_READ;
      ks_data_oe  <= 1'b0;
      ks_data_out <= '0;
    end else begin
      busy        <= (state_d != IDLE) && (state_d != DONE);
      done        <= (state_d == DONE);
      ks_e        <= e_d;
      ks_cs       <= cs_d;
      ks_dc       <= dc_d;
      ks_rw       <= rw_d;
      ks_data_oe  <= oe_d;
      ks_data_out <= do_d;
    end
  end

endmodule

// File: tb/tb_ks0108_bus_controller.sv
// Scoreboard bench: plain polled-free and auto-busy instances.
// LCD model answers reads; monitor checks each done.
module tb_ks0108_bus_controller;

  localparam int S    = 2;
  localparam int H    = 13;
  localparam int L    = 13;
  localparam int T    = S + H + L;
  localparam int LIM1 = 4;

  typedef struct {
    int         t_issue;
    int         lat;
    logic       to;
    int         nrd;
    int         nwr;
    logic       acc;
    logic       chk_rd;
    logic [7:0] rd;
    logic [1:0] cs_pin;
    logic       dc;
    logic       wr;
    logic [7:0] wd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic       req[2], wr[2], dc[2];
  logic [1:0] cs_sel[2];
  logic [7:0] wdata[2], rdata[2], ks_do[2], ks_di[2];
  logic       busy[2], done[2], tmo[2];
  logic       ks_dc[2], ks_rw[2], ks_e[2], ks_oe[2];
  logic [1:0] ks_cs[2];

  logic [7:0] chip_val[2][2];
  int         busy_left[2];
  logic       lcd_prev[2], lcd_stat[2];

  int         run[2], nrd[2], nwr[2], first_rise[2];
  logic       viol[2], badw[2], oe_seen[2], mprev[2];
  logic [1:0] acc_cs[2];
  logic       acc_dc[2], acc_rw[2];
  logic [7:0] acc_do[2];

  exp_t q0[$], q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ks0108_bus_controller #(.AUTO_BUSY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]),
    .dc(dc[0]), .cs_sel(cs_sel[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .busy(busy[0]), .done(done[0]),
    .timeout(tmo[0]), .ks_dc(ks_dc[0]), .ks_rw(ks_rw[0]),
    .ks_e(ks_e[0]), .ks_cs(ks_cs[0]), .ks_data_out(ks_do[0]),
    .ks_data_in(ks_di[0]), .ks_data_oe(ks_oe[0])
  );

  ks0108_bus_controller #(.AUTO_BUSY(1), .POLL_LIMIT(LIM1)) dut1 (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]),
    .dc(dc[1]), .cs_sel(cs_sel[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .busy(busy[1]), .done(done[1]),
    .timeout(tmo[1]), .ks_dc(ks_dc[1]), .ks_rw(ks_rw[1]),
    .ks_e(ks_e[1]), .ks_cs(ks_cs[1]), .ks_data_out(ks_do[1]),
    .ks_data_in(ks_di[1]), .ks_data_oe(ks_oe[1])
  );

  // LCD pads: status while busy count lasts, else wired-OR of chips
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ks_di[i] = '0;
      if (ks_e[i] && ks_rw[i]) begin
        if (!ks_dc[i]) begin
          ks_di[i] = (busy_left[i] > 0) ? 8'h80 : 8'h00;
        end else begin
          for (int c = 0; c < 2; c++)
            if (!ks_cs[i][c]) ks_di[i] = ks_di[i] | chip_val[i][c];
        end
      end
    end
  end

  // LCD busy countdown: one per completed status read
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ks_e[i]) begin
        lcd_stat[i] <= !ks_dc[i] && ks_rw[i];
      end else if (lcd_prev[i] && lcd_stat[i] && busy_left[i] > 0) begin
        busy_left[i] <= busy_left[i] - 1;
      end
      lcd_prev[i] <= ks_e[i];
    end
  end

  task automatic chk(string nm, int i, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, i, got, exp);
    end
  endtask

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic clear_stats(int i);
    run[i] = 0;
    nrd[i] = 0;
    nwr[i] = 0;
    first_rise[i] = -1;
    viol[i] = 1'b0;
    badw[i] = 1'b0;
    oe_seen[i] = 1'b0;
  endtask

  task automatic check_done(int i);
    exp_t e;
    if (qsize(i) == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_done[%0d] got=1 exp=0", i);
    end else begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk("latency", i, cyc - e.t_issue + 1, e.lat);
      chk("e_rise", i, first_rise[i] - e.t_issue, 1 + S);
      chk("timeout", i, tmo[i], e.to);
      chk("busy_at_done", i, busy[i], 0);
      chk("rd_pulses", i, nrd[i], e.nrd);
      chk("wr_pulses", i, nwr[i], e.nwr);
      chk("e_width", i, badw[i], 0);
      chk("oe_with_rw", i, viol[i], 0);
      if (e.acc) begin
        chk("cs_pins", i, acc_cs[i], e.cs_pin);
        chk("dc_pin", i, acc_dc[i], e.dc);
        chk("rw_pin", i, acc_rw[i], !e.wr);
        if (e.wr) chk("wdata_pins", i, acc_do[i], e.wd);
      end
      if (e.chk_rd) chk("rdata", i, rdata[i], e.rd);
    end
    clear_stats(i);
  endtask

  // Monitor: tally E pulses per transaction, score each done
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        clear_stats(i);
        mprev[i] = 1'b0;
      end else begin
        if (ks_oe[i] && ks_rw[i]) viol[i] = 1'b1;
        if (ks_e[i]) begin
          if (!mprev[i] && first_rise[i] < 0) first_rise[i] = cyc;
          run[i]++;
          oe_seen[i] = oe_seen[i] | ks_oe[i];
          acc_cs[i] = ks_cs[i];
          acc_dc[i] = ks_dc[i];
          acc_rw[i] = ks_rw[i];
          acc_do[i] = ks_do[i];
        end else if (mprev[i]) begin
          if (run[i] != H) badw[i] = 1'b1;
          if (oe_seen[i]) nwr[i]++;
          else            nrd[i]++;
          run[i] = 0;
          oe_seen[i] = 1'b0;
        end
        mprev[i] = ks_e[i];
        if (done[i]) check_done(i);
      end
    end
  end

  task automatic issue(int i, logic w, logic d, logic [1:0] cs,
                       logic [7:0] wd, int b);
    exp_t e;
    int   polls;
    logic acc;
    logic [7:0] orv;
    @(posedge clk);
    #1;
    busy_left[i] = b;
    if (i == 0)         begin polls = 0;     acc = 1'b1; end
    else if (b >= LIM1) begin polls = LIM1;  acc = 1'b0; end
    else                begin polls = b + 1; acc = 1'b1; end
    orv = '0;
    for (int c = 0; c < 2; c++)
      if (cs[c]) orv = orv | chip_val[i][c];
    e.t_issue = cyc;
    e.lat     = 1 + (polls + int'(acc)) * T + 1;
    e.to      = !acc;
    e.nrd     = polls + int'(acc && !w);
    e.nwr     = int'(acc && w);
    e.acc     = acc;
    e.chk_rd  = acc && !w;
    e.rd      = d ? orv : 8'h00;
    e.cs_pin  = ~cs;
    e.dc      = d;
    e.wr      = w;
    e.wd      = wd;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    req[i] = 1'b1;
    wr[i] = w;
    dc[i] = d;
    cs_sel[i] = cs;
    wdata[i] = wd;
    @(posedge clk);
    #1;
    chk("accept_busy", i, busy[i], 1);
    chk("timeout_clear", i, tmo[i], 0);
    req[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    while ((qsize(i) != 0 || busy[i] || done[i]) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL wait_idle[%0d] got=busy exp=idle", i);
      if (i == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  task automatic wait_e_high(int i);
    int n;
    n = 0;
    while (!ks_e[i] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL e_rise_wait[%0d] got=0 exp=1", i);
    end
  endtask

  initial begin
    int         ri, rb;
    logic       rw_, rd_;
    logic [1:0] rcs;
    logic [7:0] rwd;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      wr[i] = 1'b0;
      dc[i] = 1'b0;
      cs_sel[i] = '0;
      wdata[i] = '0;
      busy_left[i] = 0;
      chip_val[i][0] = 8'h00;
      chip_val[i][1] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, busy[i], 0);
      chk("rst_done", i, done[i], 0);
      chk("rst_timeout", i, tmo[i], 0);
      chk("rst_e", i, ks_e[i], 0);
      chk("rst_cs", i, ks_cs[i], 2'b11);
      chk("rst_dc", i, ks_dc[i], 0);
      chk("rst_rw", i, ks_rw[i], 1);
      chk("rst_oe", i, ks_oe[i], 0);
      chk("rst_rdata", i, rdata[i], 0);
      chk("rst_dout", i, ks_do[i], 0);
    end
    reset = 1'b1;

    issue(0, 1'b1, 1'b1, 2'b01, 8'hA5, 0);
    wait_idle(0);
    chip_val[0][1] = 8'h3C;
    issue(0, 1'b0, 1'b1, 2'b10, 8'h00, 0);
    wait_idle(0);
    issue(1, 1'b1, 1'b1, 2'b01, 8'h5A, 3);
    wait_idle(1);
    issue(1, 1'b1, 1'b1, 2'b01, 8'h11, 9);
    wait_idle(1);
    issue(1, 1'b1, 1'b0, 2'b10, 8'h22, 0);
    wait_idle(1);

    issue(0, 1'b1, 1'b1, 2'b01, 8'h77, 0);
    wait_e_high(0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_e", 0, ks_e[0], 0);
    chk("abort_cs", 0, ks_cs[0], 2'b11);
    chk("abort_busy", 0, busy[0], 0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(0, 1'b1, 1'b0, 2'b10, 8'h96, 0);
    wait_idle(0);

    issue(0, 1'b1, 1'b1, 2'b11, 8'hC3, 0);
    wait_e_high(0);
    req[0] = 1'b1;
    wdata[0] = 8'h18;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    wait_idle(0);
    repeat (40) @(posedge clk);

    for (int k = 0; k < 30; k++) begin
      ri  = k % 2;
      rw_ = 1'($urandom_range(0, 1));
      rd_ = (ri == 1 && !rw_) ? 1'b1 : 1'($urandom_range(0, 1));
      rcs = 2'($urandom_range(1, 3));
      rwd = 8'($urandom);
      rb  = (ri == 1) ? int'($urandom_range(0, 5)) : 0;
      chip_val[ri][0] = 8'($urandom);
      chip_val[ri][1] = 8'($urandom);
      issue(ri, rw_, rd_, rcs, rwd, rb);
      wait_idle(ri);
    end
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
